// File: rtl/trojan_pkg.sv
// Shared types and default sizes for the sequential Trojan trigger.
package trojan_pkg;

  localparam int unsigned NTrigDef = 8;
  localparam int unsigned VwDef    = 1;
  localparam int unsigned CntWDef  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StFire  = 2'd2
  } trojan_state_e;

endpackage

// File: rtl/trojan_match.sv
// Masked equality compare of the trigger nets against a fixed pattern.
module trojan_match #(
  parameter int unsigned         N_TRIG     = 8,
  parameter logic [N_TRIG-1:0]   MATCH_VAL  = {N_TRIG{1'b1}},
  parameter logic [N_TRIG-1:0]   MATCH_MASK = {N_TRIG{1'b1}}
) (
  input  logic [N_TRIG-1:0] trig_i,
  output logic              match_o
);

  assign match_o = (((trig_i ^ MATCH_VAL) & MATCH_MASK) == '0);

endmodule

// File: rtl/seq_trojan_trigger.sv
// Time-bomb trigger: fires after THRESH consecutive masked matches and XORs the victim bus.
// Define TROJAN_TRIG_DECAY_EN to make a mismatch decrement the run count instead of clearing it.
module seq_trojan_trigger
  import trojan_pkg::*;
#(
  parameter int unsigned       N_TRIG       = NTrigDef,
  parameter logic [N_TRIG-1:0] MATCH_VAL    = {N_TRIG{1'b1}},
  parameter logic [N_TRIG-1:0] MATCH_MASK   = {N_TRIG{1'b1}},
  parameter int unsigned       VW           = VwDef,
  parameter logic [VW-1:0]     PAYLOAD_MASK = {VW{1'b1}},
  parameter int unsigned       CNT_W        = CntWDef,
  parameter int unsigned       THRESH       = 10,
  parameter bit                STICKY       = 1'b1,
  parameter int unsigned       FIRE_LEN     = 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [N_TRIG-1:0] TRIG_IN,
  input  logic [VW-1:0]     VICTIM_IN,
  output logic [VW-1:0]     VICTIM_OUT,
  output logic              TRIG_OUT,
  output logic [CNT_W-1:0]  MATCH_CNT
);

  // Both limits must fit in the counter so it can never wrap.
  if (THRESH < 1 || THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
    $error("THRESH out of range 1..2^CNT_W-1");
  end
  if (FIRE_LEN < 1 || FIRE_LEN > (2 ** CNT_W) - 1) begin : g_bad_fire_len
    $error("FIRE_LEN out of range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] ThreshC   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] FireLastC = CNT_W'(FIRE_LEN - 1);

  logic             match;
  trojan_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fired_q;
  logic [CNT_W-1:0] cnt_inc;

  trojan_match #(
    .N_TRIG     (N_TRIG),
    .MATCH_VAL  (MATCH_VAL),
    .MATCH_MASK (MATCH_MASK)
  ) u_match (
    .trig_i  (TRIG_IN),
    .match_o (match)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match && THRESH == 1) begin
            state_q <= StFire;
            cnt_q   <= '0;
            fired_q <= 1'b1;
          end else if (match) begin
            state_q <= StCount;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        StCount: begin
          if (match && cnt_inc == ThreshC) begin
            state_q <= StFire;
            cnt_q   <= '0;
            fired_q <= 1'b1;
          end else if (match) begin
            cnt_q   <= cnt_inc;
          end else begin
`ifdef TROJAN_TRIG_DECAY_EN
            // Noisy windows only lose one step per miss.
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q - CNT_W'(1);
            end
`else
            state_q <= StIdle;
            cnt_q   <= '0;
`endif
          end
        end
        StFire: begin
          // Sticky mode holds forever; pulse mode reuses cnt as the fire-cycle timer.
          if (!STICKY) begin
            if (cnt_q == FireLastC) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              fired_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_inc;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          fired_q <= 1'b0;
        end
      endcase
    end
  end

  assign TRIG_OUT   = fired_q;
  assign MATCH_CNT  = cnt_q;
  assign VICTIM_OUT = VICTIM_IN ^ (PAYLOAD_MASK & {VW{fired_q}});

endmodule

// File: tb/tb_seq_trojan_trigger.sv
// Scoreboard bench for seq_trojan_trigger: default, pulse-mode and masked-compare instances.
module tb_seq_trojan_trigger;

  typedef struct {
    logic [3:0] cnt;
    logic       trig;
    logic [3:0] vout;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic       CK = 1'b0;
  logic       RST = 1'b1;

  logic [7:0] trig_def = 8'hFF;
  logic [0:0] vin_def  = 1'b0;
  logic [0:0] vout_def;
  logic       to_def;
  logic [3:0] cnt_def;

  logic [7:0] trig_pls = 8'hFF;
  logic [3:0] vin_pls  = 4'h0;
  logic [3:0] vout_pls;
  logic       to_pls;
  logic [3:0] cnt_pls;

  logic [7:0] trig_msk = 8'h00;
  logic [0:0] vin_msk  = 1'b0;
  logic [0:0] vout_msk;
  logic       to_msk;
  logic [3:0] cnt_msk;

  always #5 CK = ~CK;

  seq_trojan_trigger u_def (
    .CK         (CK),
    .RST        (RST),
    .TRIG_IN    (trig_def),
    .VICTIM_IN  (vin_def),
    .VICTIM_OUT (vout_def),
    .TRIG_OUT   (to_def),
    .MATCH_CNT  (cnt_def)
  );

  seq_trojan_trigger #(
    .VW           (4),
    .PAYLOAD_MASK (4'b1010),
    .STICKY       (1'b0),
    .FIRE_LEN     (3)
  ) u_pls (
    .CK         (CK),
    .RST        (RST),
    .TRIG_IN    (trig_pls),
    .VICTIM_IN  (vin_pls),
    .VICTIM_OUT (vout_pls),
    .TRIG_OUT   (to_pls),
    .MATCH_CNT  (cnt_pls)
  );

  seq_trojan_trigger #(
    .MATCH_VAL  (8'h05),
    .MATCH_MASK (8'h0F)
  ) u_msk (
    .CK         (CK),
    .RST        (RST),
    .TRIG_IN    (trig_msk),
    .VICTIM_IN  (vin_msk),
    .VICTIM_OUT (vout_msk),
    .TRIG_OUT   (to_msk),
    .MATCH_CNT  (cnt_msk)
  );

  task automatic pulse_reset();
    RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1'b1;
    trig_def = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      vin_def = 1'(i);
      sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: {3'b0, 1'(i)}});
      @(posedge CK); #1;
      e = sb.pop_front();
      n_checks++;
      if (cnt_def !== e.cnt || to_def !== e.trig || vout_def !== e.vout[0]) begin
        n_errors++;
        $display("FAIL reset cyc %0d: got cnt=%0d trig=%b vout=%b, want cnt=%0d trig=%b vout=%b",
                 i, cnt_def, to_def, vout_def, e.cnt, e.trig, e.vout[0]);
      end
    end
    n_checks++;
    if (cnt_pls !== 4'd0 || to_pls !== 1'b0 || cnt_msk !== 4'd0 || to_msk !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_others: got pls cnt=%0d trig=%b msk cnt=%0d trig=%b, want all 0",
               cnt_pls, to_pls, cnt_msk, to_msk);
    end
    RST = 1'b0;
  endtask

  task automatic test_threshold();
    exp_t e;
    pulse_reset();
    vin_def = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      trig_def = (i <= 10) ? 8'hFF : 8'h00;
      if (i < 10) sb.push_back('{cnt: 4'(i), trig: 1'b0, vout: 4'h0});
      else        sb.push_back('{cnt: 4'd0, trig: 1'b1, vout: 4'h1});
      @(posedge CK); #1;
      e = sb.pop_front();
      n_checks++;
      if (cnt_def !== e.cnt || to_def !== e.trig || vout_def !== e.vout[0]) begin
        n_errors++;
        $display("FAIL threshold cyc %0d: got cnt=%0d trig=%b vout=%b, want cnt=%0d trig=%b vout=%b",
                 i, cnt_def, to_def, vout_def, e.cnt, e.trig, e.vout[0]);
      end
    end
  endtask

  task automatic test_broken_run();
    exp_t e;
    int   second_len;
    pulse_reset();
    vin_def = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      trig_def = 8'hFF;
      sb.push_back('{cnt: 4'(i), trig: 1'b0, vout: 4'h1});
    end
`ifdef TROJAN_TRIG_DECAY_EN
    sb.push_back('{cnt: 4'd8, trig: 1'b0, vout: 4'h1});
    sb.push_back('{cnt: 4'd9, trig: 1'b0, vout: 4'h1});
    sb.push_back('{cnt: 4'd0, trig: 1'b1, vout: 4'h0});
    second_len = 2;
`else
    sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: 4'h1});
    for (int i = 1; i <= 9; i++) sb.push_back('{cnt: 4'(i), trig: 1'b0, vout: 4'h1});
    sb.push_back('{cnt: 4'd0, trig: 1'b1, vout: 4'h0});
    second_len = 10;
`endif
    for (int i = 0; i < 10 + second_len; i++) begin
      trig_def = (i == 9) ? 8'hFE : 8'hFF;
      @(posedge CK); #1;
      e = sb.pop_front();
      n_checks++;
      if (cnt_def !== e.cnt || to_def !== e.trig || vout_def !== e.vout[0]) begin
        n_errors++;
        $display("FAIL broken_run cyc %0d: got cnt=%0d trig=%b vout=%b, want cnt=%0d trig=%b vout=%b",
                 i, cnt_def, to_def, vout_def, e.cnt, e.trig, e.vout[0]);
      end
    end
  endtask

  task automatic test_pulse();
    exp_t e;
    int   p;
    pulse_reset();
    trig_pls = 8'hFF;
    vin_pls  = 4'h0;
    // Period is 3 fire cycles plus 10 counting cycles; first fire at cycle 10.
    for (int k = 1; k <= 27; k++) begin
      p = (k + 3) % 13;
      if (p < 3)       sb.push_back('{cnt: 4'(p), trig: 1'b1, vout: 4'hA});
      else if (p == 3) sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: 4'h0});
      else             sb.push_back('{cnt: 4'(p - 3), trig: 1'b0, vout: 4'h0});
      @(posedge CK); #1;
      e = sb.pop_front();
      n_checks++;
      if (cnt_pls !== e.cnt || to_pls !== e.trig || vout_pls !== e.vout) begin
        n_errors++;
        $display("FAIL pulse cyc %0d: got cnt=%0d trig=%b vout=%h, want cnt=%0d trig=%b vout=%h",
                 k, cnt_pls, to_pls, vout_pls, e.cnt, e.trig, e.vout);
      end
    end
  endtask

  task automatic test_masked();
    exp_t e;
    pulse_reset();
    vin_msk = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k == 0) begin
        trig_msk = 8'hF4;
        sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: 4'h0});
      end else begin
        trig_msk = k[0] ? 8'h35 : 8'hC5;
        if (k < 10) sb.push_back('{cnt: 4'(k), trig: 1'b0, vout: 4'h0});
        else        sb.push_back('{cnt: 4'd0, trig: 1'b1, vout: 4'h1});
      end
      @(posedge CK); #1;
      e = sb.pop_front();
      n_checks++;
      if (cnt_msk !== e.cnt || to_msk !== e.trig || vout_msk !== e.vout[0]) begin
        n_errors++;
        $display("FAIL masked cyc %0d: got cnt=%0d trig=%b vout=%b, want cnt=%0d trig=%b vout=%b",
                 k, cnt_msk, to_msk, vout_msk, e.cnt, e.trig, e.vout[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    pulse_reset();
    vin_def  = 1'b1;
    trig_def = 8'hFF;
    // 6 matches, reset in COUNT, 10 matches, reset in FIRE, one idle cycle.
    for (int i = 1; i <= 6; i++) sb.push_back('{cnt: 4'(i), trig: 1'b0, vout: 4'h1});
    sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: 4'h1});
    for (int i = 1; i <= 9; i++) sb.push_back('{cnt: 4'(i), trig: 1'b0, vout: 4'h1});
    sb.push_back('{cnt: 4'd0, trig: 1'b1, vout: 4'h0});
    sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: 4'h1});
    sb.push_back('{cnt: 4'd0, trig: 1'b0, vout: 4'h1});
    for (int i = 0; i < 19; i++) begin
      RST      = (i == 6 || i == 17);
      trig_def = (i == 18) ? 8'h00 : 8'hFF;
      @(posedge CK); #1;
      e = sb.pop_front();
      n_checks++;
      if (cnt_def !== e.cnt || to_def !== e.trig || vout_def !== e.vout[0]) begin
        n_errors++;
        $display("FAIL reset_mid cyc %0d: got cnt=%0d trig=%b vout=%b, want cnt=%0d trig=%b vout=%b",
                 i, cnt_def, to_def, vout_def, e.cnt, e.trig, e.vout[0]);
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_broken_run();
    test_pulse();
    test_masked();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
